t00_ssscan_dec: RTL and testbench
=================================

Name: t00_ssscan_dec

Overview:
- Reverse direction of the team's hex-to-seven-segment decoder: watches a time-multiplexed seven-segment display bus and recovers the hex digit shown on each position.
- Inputs are a segment pattern plus a one-hot digit select.
- Each captured pattern is mapped back to a 4-bit value and held in a per-digit register bank.
- Used as a display readback/self-check monitor beside the display driver; results are visible to the test harness or CPU.

Parameters:
- NUM_DIGITS, 8, number of display positions (2..16); width of dig_sel.
- STABLE_CYCLES, 4, consecutive identical samples required before a capture (2..255).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- seg_in  input  8  segment pattern; bit7=dp, bits6..0 = g,f,e,d,c,b,a
- dig_sel  input  NUM_DIGITS  one-hot digit select of the scanned position
- clear  input  1  synchronous clear of captured state
- hex_out  output  4*NUM_DIGITS  recovered digits; digit i at [4i+3:4i]
- dp_out  output  NUM_DIGITS  captured decimal-point bit per digit
- digit_valid  output  NUM_DIGITS  1 = slot holds a legal hex pattern
- capture_strobe  output  1  one-cycle pulse per capture
- capture_idx  output  $clog2(NUM_DIGITS)  index captured with the current strobe
- err  output  1  sticky; an illegal pattern was captured
- err_idx  output  $clog2(NUM_DIGITS)  index of the most recent illegal capture

Behaviour:
- Reset (rst=1 at an edge): all outputs 0, stability counter and sample registers 0. Reset has priority over everything else.
- Sampling: seg_in/dig_sel are registered every cycle. A sample "matches" when it equals the previous sample and dig_sel is exactly one-hot.
- The stability counter increments on a match (saturating) and reloads to 1 on a non-match.
- A zero or multi-hot dig_sel sample forces the counter to 0; nothing is captured until a fresh one-hot window completes.
- Capture rule: when STABLE_CYCLES consecutive identical one-hot samples have been taken, exactly one capture occurs.
  - capture_strobe, capture_idx and the slot update become visible in the cycle after the STABLE_CYCLES-th sampling edge.
  - No further capture occurs until the inputs change; a held pattern never re-strobes.
- Pattern map on seg_in[6:0] (dp ignored for decode):
  - 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07
  - 8:7F, 9:67, A:77, b:7C, C:39, d:5E, E:79, F:71
- Slot update at capture i:
  - Legal pattern: hex_out[i] = value, digit_valid[i] = 1, dp_out[i] = seg_in[7].
  - Blank (seg_in[6:0] = 00): hex_out[i] = 0, digit_valid[i] = 0, dp_out[i] = seg_in[7]; err unaffected.
  - Any other pattern: hex_out[i] = 0, digit_valid[i] = 0, dp_out[i] = seg_in[7], err = 1, err_idx = i.
- Other slots are never modified by a capture.
- clear=1: hex_out, dp_out, digit_valid, err and err_idx go to 0 next cycle, and the stability counter goes to 0.
  - If a capture would fire on the same edge, clear wins and the capture (and strobe) is dropped.
- Simultaneous illegal captures cannot occur; there is only one capture per cycle.
- err stays 1 until clear or rst; err_idx tracks the latest illegal capture.
- No combinational path from inputs to outputs; all outputs are registered.

Decomposition:
- Package t00_ssd_pkg holds:
  - The 16 segment-pattern constants (SEG_HEX_0..SEG_HEX_F).
  - SEG_BLANK.
  - Bit-position constants SEG_DP / SEG_A..SEG_G.
- The existing forward decoder is to be refactored onto the same constants.
- One combinational sub-module, t00_ssrev: 7-bit pattern in → {legal, blank, hex[3:0]} out; instantiated once.

Test Plan:
- Reset, then hold seg_in=5B, dig_sel=0000_0100 for 4 cycles → exactly one capture_strobe, capture_idx=2, hex_out[11:8]=2, digit_valid[2]=1; stays held for 20 more cycles with no further strobe.
- Same pattern held only 3 cycles, then dig_sel changes → no strobe, all slots unchanged.
- Scan 8 digits, each held 6 cycles, with patterns 3F,06,5B,4F,66,6D,7D,07 → 8 strobes, hex_out=32'h7654_3210, digit_valid=FF.
- seg_in=49 (illegal) on digit 5 → err=1, err_idx=5, digit_valid[5]=0. Next, legal 7F on digit 5 → digit 5 valid with value 8, err still 1. Pulse clear → all zero.
- dig_sel=0000_0011 held 10 cycles → no strobe. dig_sel=0 → no strobe. seg_in=80 on digit 0 → blank: dp_out[0]=1, digit_valid[0]=0, err=0.
- Assert clear on the same edge as a completing window → no strobe, slot stays 0. Assert rst mid-window (after 2 samples) → a full 4-sample window is needed again before a capture.

Source files
------------

// File: rtl/t00_ssd_pkg.sv
// Shared seven-segment constants: segment bit positions, the 16 hex glyphs
// and the blank glyph. The forward hex-to-segment helper lives here as well
// so both directions of the display path share one glyph table.
package t00_ssd_pkg;

  // Bit positions within an 8-bit segment bus {dp, g, f, e, d, c, b, a}
  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  // Glyphs on bits g..a (dp excluded)
  localparam logic [6:0] SEG_HEX_0 = 7'h3F;
  localparam logic [6:0] SEG_HEX_1 = 7'h06;
  localparam logic [6:0] SEG_HEX_2 = 7'h5B;
  localparam logic [6:0] SEG_HEX_3 = 7'h4F;
  localparam logic [6:0] SEG_HEX_4 = 7'h66;
  localparam logic [6:0] SEG_HEX_5 = 7'h6D;
  localparam logic [6:0] SEG_HEX_6 = 7'h7D;
  localparam logic [6:0] SEG_HEX_7 = 7'h07;
  localparam logic [6:0] SEG_HEX_8 = 7'h7F;
  localparam logic [6:0] SEG_HEX_9 = 7'h67;
  localparam logic [6:0] SEG_HEX_A = 7'h77;
  localparam logic [6:0] SEG_HEX_B = 7'h7C;
  localparam logic [6:0] SEG_HEX_C = 7'h39;
  localparam logic [6:0] SEG_HEX_D = 7'h5E;
  localparam logic [6:0] SEG_HEX_E = 7'h79;
  localparam logic [6:0] SEG_HEX_F = 7'h71;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Forward decoder: hex digit to glyph (used by the display driver side)
  function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
    logic [6:0] seg;
    case (hex)
      4'h0: seg = SEG_HEX_0;
      4'h1: seg = SEG_HEX_1;
      4'h2: seg = SEG_HEX_2;
      4'h3: seg = SEG_HEX_3;
      4'h4: seg = SEG_HEX_4;
      4'h5: seg = SEG_HEX_5;
      4'h6: seg = SEG_HEX_6;
      4'h7: seg = SEG_HEX_7;
      4'h8: seg = SEG_HEX_8;
      4'h9: seg = SEG_HEX_9;
      4'hA: seg = SEG_HEX_A;
      4'hB: seg = SEG_HEX_B;
      4'hC: seg = SEG_HEX_C;
      4'hD: seg = SEG_HEX_D;
      4'hE: seg = SEG_HEX_E;
      default: seg = SEG_HEX_F;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/t00_ssrev.sv
// Reverse glyph lookup: 7-bit segment pattern to hex value, flagging
// legal glyphs and the all-off blank pattern separately.
module t00_ssrev
  import t00_ssd_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic       legal_o,
  output logic       blank_o,
  output logic [3:0] hex_o
);

  // Pure table lookup; anything not in the glyph set is neither legal nor blank
  always_comb begin
    legal_o = 1'b1;
    blank_o = 1'b0;
    hex_o   = 4'h0;
    case (seg_i)
      SEG_HEX_0: hex_o = 4'h0;
      SEG_HEX_1: hex_o = 4'h1;
      SEG_HEX_2: hex_o = 4'h2;
      SEG_HEX_3: hex_o = 4'h3;
      SEG_HEX_4: hex_o = 4'h4;
      SEG_HEX_5: hex_o = 4'h5;
      SEG_HEX_6: hex_o = 4'h6;
      SEG_HEX_7: hex_o = 4'h7;
      SEG_HEX_8: hex_o = 4'h8;
      SEG_HEX_9: hex_o = 4'h9;
      SEG_HEX_A: hex_o = 4'hA;
      SEG_HEX_B: hex_o = 4'hB;
      SEG_HEX_C: hex_o = 4'hC;
      SEG_HEX_D: hex_o = 4'hD;
      SEG_HEX_E: hex_o = 4'hE;
      SEG_HEX_F: hex_o = 4'hF;
      SEG_BLANK: begin
        legal_o = 1'b0;
        blank_o = 1'b1;
      end
      default:   legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/t00_ssscan_dec.sv
// Seven-segment scan readback monitor. Samples the multiplexed display bus,
// waits for a pattern/select pair to be stable for STABLE_CYCLES samples,
// then decodes the glyph once into the selected digit slot.
module t00_ssscan_dec
  import t00_ssd_pkg::*;
#(
  parameter int NUM_DIGITS    = 8,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    seg_in,
  input  logic [NUM_DIGITS-1:0]         dig_sel,
  input  logic                          clear,
  output logic [4*NUM_DIGITS-1:0]       hex_out,
  output logic [NUM_DIGITS-1:0]         dp_out,
  output logic [NUM_DIGITS-1:0]         digit_valid,
  output logic                          capture_strobe,
  output logic [$clog2(NUM_DIGITS)-1:0] capture_idx,
  output logic                          err,
  output logic [$clog2(NUM_DIGITS)-1:0] err_idx
);

  localparam int         IW       = $clog2(NUM_DIGITS);
  localparam logic [7:0] CNT_MAX  = 8'(STABLE_CYCLES);
  localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);
  localparam logic [NUM_DIGITS-1:0] SEL_ONE = {{(NUM_DIGITS-1){1'b0}}, 1'b1};

  logic [7:0]              seg_q;
  logic [NUM_DIGITS-1:0]   sel_q;
  logic [7:0]              cnt_q, cnt_d;
  logic                    sel_onehot, match, capture_d;
  logic [IW-1:0]           sel_idx;
  logic [NUM_DIGITS-1:0]   slot_we;
  logic                    rev_legal, rev_blank;
  logic [3:0]              rev_hex;

  logic [4*NUM_DIGITS-1:0] hex_q;
  logic [NUM_DIGITS-1:0]   dp_q, valid_q;
  logic                    strobe_q, err_q;
  logic [IW-1:0]           cap_idx_q, err_idx_q;

  t00_ssrev u_rev (
    .seg_i   (seg_in[SEG_G:SEG_A]),
    .legal_o (rev_legal),
    .blank_o (rev_blank),
    .hex_o   (rev_hex)
  );

  // Stability tracking: a match is an identical, exactly one-hot repeat sample
  always_comb begin
    sel_onehot = (dig_sel != '0) && ((dig_sel & (dig_sel - SEL_ONE)) == '0);
    match      = sel_onehot && (seg_in == seg_q) && (dig_sel == sel_q);
    cnt_d      = cnt_q;
    if (!sel_onehot) begin
      cnt_d = 8'd0;
    end else if (match) begin
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + 8'd1;
    end else begin
      cnt_d = 8'd1;
    end
    // Fires only on the transition into the saturated count, so a held
    // pattern captures once; clear on the same edge drops the capture.
    capture_d  = match && (cnt_q == CNT_LAST) && !clear;
  end

  // One-hot select to binary slot index
  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (dig_sel[i]) sel_idx = sel_idx | IW'(i);
    end
  end

  // Per-slot write enables
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_we
    assign slot_we[gi] = capture_d & dig_sel[gi];
  end

  // Input sample registers, stability counter and capture strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q     <= '0;
      sel_q     <= '0;
      cnt_q     <= '0;
      strobe_q  <= 1'b0;
      cap_idx_q <= '0;
    end else begin
      seg_q    <= seg_in;
      sel_q    <= dig_sel;
      cnt_q    <= clear ? 8'd0 : cnt_d;
      strobe_q <= capture_d;
      if (capture_d) cap_idx_q <= sel_idx;
    end
  end

  // Digit slot bank and sticky error; only the selected slot is written
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      hex_q     <= '0;
      dp_q      <= '0;
      valid_q   <= '0;
      err_q     <= 1'b0;
      err_idx_q <= '0;
    end else if (capture_d) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (slot_we[i]) begin
          hex_q[4*i +: 4] <= rev_legal ? rev_hex : 4'h0;
          dp_q[i]         <= seg_in[SEG_DP];
          valid_q[i]      <= rev_legal;
        end
      end
      if (!rev_legal && !rev_blank) begin
        err_q     <= 1'b1;
        err_idx_q <= sel_idx;
      end
    end
  end

  assign hex_out        = hex_q;
  assign dp_out         = dp_q;
  assign digit_valid    = valid_q;
  assign capture_strobe = strobe_q;
  assign capture_idx    = cap_idx_q;
  assign err            = err_q;
  assign err_idx        = err_idx_q;

endmodule

// File: tb/tb_t00_ssscan_dec.sv
// Bench for t00_ssscan_dec: drives hold windows on the display bus, queues the
// captures each window should produce and checks them as strobes appear.
module tb_t00_ssscan_dec;

  localparam int ND     = 8;
  localparam int STABLE = 4;

  logic          clk = 1'b0;
  logic          rst, clear;
  logic [7:0]    seg_in;
  logic [ND-1:0] dig_sel;
  logic [4*ND-1:0] hex_out;
  logic [ND-1:0] dp_out, digit_valid;
  logic          capture_strobe, err;
  logic [2:0]    capture_idx, err_idx;

  t00_ssscan_dec #(.NUM_DIGITS(ND), .STABLE_CYCLES(STABLE)) dut (
    .clk            (clk),
    .rst            (rst),
    .seg_in         (seg_in),
    .dig_sel        (dig_sel),
    .clear          (clear),
    .hex_out        (hex_out),
    .dp_out         (dp_out),
    .digit_valid    (digit_valid),
    .capture_strobe (capture_strobe),
    .capture_idx    (capture_idx),
    .err            (err),
    .err_idx        (err_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         due;
    logic [2:0] idx;
    logic [3:0] hex;
    logic       valid;
    logic       dp;
    logic       err;
    logic [2:0] eidx;
  } cap_t;

  typedef struct {
    logic [7:0] seg;
    logic [7:0] sel;
    int         hold;
    bit         cap;
  } vec_t;

  cap_t       sbq[$];
  vec_t       tbl[16];
  logic [6:0] pat[16];
  int         checks = 0;
  int         errors = 0;
  int         tick_n = 0;
  logic       err_model = 1'b0;
  logic [2:0] eidx_model = 3'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (tick %0d)", name, act, exp, tick_n);
    end
  endtask

  // Bench-side glyph lookup: {legal, hex}
  function automatic logic [4:0] model_dec(input logic [6:0] p);
    logic [4:0] r;
    r = 5'b0;
    for (int k = 0; k < 16; k++) begin
      if (pat[k] == p) r = {1'b1, 4'(k)};
    end
    return r;
  endfunction

  // Advance one clock; compare any strobe against the scoreboard head
  task automatic tick();
    cap_t r;
    @(posedge clk);
    #1;
    tick_n++;
    if (capture_strobe) begin
      if (sbq.size() == 0) begin
        check("unexpected_strobe", 32'd1, 32'd0);
      end else begin
        r = sbq.pop_front();
        check("cap_time", tick_n, r.due);
        check("cap_idx", 32'(capture_idx), 32'(r.idx));
        check("cap_hex", 32'(hex_out[r.idx*4 +: 4]), 32'(r.hex));
        check("cap_valid", 32'(digit_valid[r.idx]), 32'(r.valid));
        check("cap_dp", 32'(dp_out[r.idx]), 32'(r.dp));
        check("cap_err", 32'(err), 32'(r.err));
        check("cap_err_idx", 32'(err_idx), 32'(r.eidx));
      end
    end else if (sbq.size() > 0 && sbq[0].due <= tick_n) begin
      r = sbq.pop_front();
      check("missing_strobe", 32'd0, 32'd1);
    end
  endtask

  task automatic expect_cap(input logic [7:0] seg, input logic [7:0] sel);
    cap_t r;
    logic [4:0] d;
    d = model_dec(seg[6:0]);
    r.due = tick_n + STABLE;
    r.idx = 3'd0;
    for (int k = 0; k < ND; k++) if (sel[k]) r.idx = 3'(k);
    r.valid = d[4];
    r.hex = d[4] ? d[3:0] : 4'h0;
    r.dp = seg[7];
    if (!d[4] && seg[6:0] != 7'h00) begin
      err_model  = 1'b1;
      eidx_model = r.idx;
    end
    r.err  = err_model;
    r.eidx = eidx_model;
    sbq.push_back(r);
  endtask

  task automatic drive(input logic [7:0] seg, input logic [7:0] sel, input int n, input bit cap);
    seg_in  = seg;
    dig_sel = sel;
    if (cap) expect_cap(seg, sel);
    repeat (n) tick();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_hex"}, hex_out, 32'h0);
    check({tag, "_dp"}, 32'(dp_out), 32'h0);
    check({tag, "_valid"}, 32'(digit_valid), 32'h0);
    check({tag, "_err"}, 32'(err), 32'h0);
    check({tag, "_err_idx"}, 32'(err_idx), 32'h0);
  endtask

  initial begin
    pat = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
            7'h7F, 7'h67, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    // Digits 0..7 with 0..7 held 6 cycles, then 8..F held exactly 4 with dp on odd
    for (int k = 0; k < 8; k++)
      tbl[k] = '{seg: {1'b0, pat[k]}, sel: 8'(1 << k), hold: 6, cap: 1'b1};
    for (int k = 8; k < 16; k++)
      tbl[k] = '{seg: {k[0], pat[k]}, sel: 8'(1 << (k - 8)), hold: STABLE, cap: 1'b1};

    rst = 1'b1; clear = 1'b0; seg_in = 8'h00; dig_sel = '0;
    repeat (3) tick();
    check("rst_strobe", 32'(capture_strobe), 32'h0);
    check("rst_idx", 32'(capture_idx), 32'h0);
    check_zero("rst");
    rst = 1'b0;

    // Single capture, then long hold without re-strobe
    drive(8'h5B, 8'h04, STABLE, 1'b1);
    drive(8'h5B, 8'h04, 20, 1'b0);
    check("d2_hex", 32'(hex_out[11:8]), 32'h2);
    check("d2_valid", 32'(digit_valid), 32'h04);

    // Window one sample short, then select changes
    drive(8'h4F, 8'h08, STABLE - 1, 1'b0);
    drive(8'h4F, 8'h00, 3, 1'b0);
    check("short_hex", hex_out, 32'h0000_0200);
    check("short_valid", 32'(digit_valid), 32'h04);

    // Table-driven scan of all 16 glyphs
    for (int v = 0; v < 16; v++) begin
      drive(tbl[v].seg, tbl[v].sel, tbl[v].hold, tbl[v].cap);
      if (v == 7) begin
        check("scan1_hex", hex_out, 32'h7654_3210);
        check("scan1_valid", 32'(digit_valid), 32'hFF);
      end
    end
    check("scan2_hex", hex_out, 32'hFEDC_BA98);
    check("scan2_dp", 32'(dp_out), 32'hAA);
    check("scan_err", 32'(err), 32'h0);

    // Illegal glyph, then legal glyph on the same slot, then clear
    drive(8'h49, 8'h20, 6, 1'b1);
    check("ill_err", 32'(err), 32'h1);
    check("ill_err_idx", 32'(err_idx), 32'h5);
    check("ill_valid5", 32'(digit_valid[5]), 32'h0);
    drive(8'h7F, 8'h20, 6, 1'b1);
    check("fix_hex5", 32'(hex_out[23:20]), 32'h8);
    check("fix_err", 32'(err), 32'h1);
    clear = 1'b1; dig_sel = '0;
    tick();
    clear = 1'b0; err_model = 1'b0; eidx_model = 3'd0;
    tick();
    check_zero("clr");

    // Multi-hot and zero selects never capture; blank with dp on digit 0
    drive(8'h3F, 8'h03, 10, 1'b0);
    drive(8'h3F, 8'h00, 3, 1'b0);
    drive(8'h80, 8'h01, 6, 1'b1);
    check("blank_dp", 32'(dp_out), 32'h01);
    check("blank_valid", 32'(digit_valid), 32'h00);
    check("blank_err", 32'(err), 32'h0);

    // Clear coinciding with the completing sample drops the capture
    drive(8'h06, 8'h02, STABLE - 1, 1'b0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    drive(8'h06, 8'h00, 3, 1'b0);
    check("clrwin_hex", hex_out, 32'h0);
    check("clrwin_valid", 32'(digit_valid), 32'h0);

    // Reset mid-window restarts the full window
    drive(8'h66, 8'h08, 2, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0; err_model = 1'b0; eidx_model = 3'd0;
    drive(8'h66, 8'h08, STABLE + 3, 1'b1);
    check("rstwin_hex", hex_out, 32'h0000_4000);
    check("rstwin_valid", 32'(digit_valid), 32'h08);

    check("sb_empty", 32'(sbq.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
